// File: rtl/lis_pkg.sv
// lis_pkg: shared definitions for the LIS processor core.
//   - opcode encodings of the byte-coded instruction set
//   - control FSM state enumeration
//   - instr_len(): total encoded length in bytes (opcode + operands)
package lis_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_MOV  = 8'h01;
    localparam logic [7:0] OP_LDI  = 8'h02;
    localparam logic [7:0] OP_ADD  = 8'h10;
    localparam logic [7:0] OP_SUB  = 8'h11;
    localparam logic [7:0] OP_AND  = 8'h12;
    localparam logic [7:0] OP_OR   = 8'h13;
    localparam logic [7:0] OP_XOR  = 8'h14;
    localparam logic [7:0] OP_SHL  = 8'h15;
    localparam logic [7:0] OP_SHR  = 8'h16;
    localparam logic [7:0] OP_LDB  = 8'h20;
    localparam logic [7:0] OP_STB  = 8'h21;
    localparam logic [7:0] OP_PUSH = 8'h30;
    localparam logic [7:0] OP_POP  = 8'h31;
    localparam logic [7:0] OP_JMP  = 8'h40;
    localparam logic [7:0] OP_JZ   = 8'h41;
    localparam logic [7:0] OP_JNZ  = 8'h42;
    localparam logic [7:0] OP_CALL = 8'h50;
    localparam logic [7:0] OP_RET  = 8'h51;
    localparam logic [7:0] OP_HLT  = 8'hFF;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_OPERAND,
        ST_EXEC,
        ST_MEM,
        ST_STK2,
        ST_HALT
    } state_e;

    // Undefined opcodes behave as 1-byte NOPs.
    function automatic logic [2:0] instr_len(input logic [7:0] op);
        logic [2:0] len;
        case (op)
            OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SHL, OP_SHR, OP_LDB, OP_STB:      len = 3'd3;
            OP_LDI, OP_JZ, OP_JNZ:               len = 3'd6;
            OP_PUSH, OP_POP:                     len = 3'd2;
            OP_JMP, OP_CALL:                     len = 3'd5;
            default:                             len = 3'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/lis_alu.sv
// lis_alu: combinational 32-bit ALU for opcodes 0x10..0x16.
//   op_i : opcode byte
//   a_i  : first operand (rA contents)
//   b_i  : second operand (rB contents; bits [4:0] are the shift amount)
//   y_o  : result, modulo 2^32; zero for opcodes outside the ALU group
module lis_alu
    import lis_pkg::*;
(
    input  logic [7:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_SHL:  y_o = a_i << b_i[4:0];
            OP_SHR:  y_o = a_i >> b_i[4:0];
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/lis_cpu.sv
// lis_cpu: 8-bit-fetch, 32-bit-datapath LIS processor core.
//   clock, reset (sync, active-high), ce (clock enable; 0 freezes state)
//   address/in/out/we : byte memory bus (fetch and LDB/STB data)
//   ra/rb/r1/r2/ro/rw : external 256x32 register file (ra is also write addr)
//   sp/si/so/sw       : external 1024x32 stack, full-descending
// Bus outputs are decoded from registered state; ro/so carry data that the
// external arrays return in the same cycle, so they follow r1/r2/si/in.
module lis_cpu
    import lis_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    output logic [31:0] address,
    input  logic [7:0]  in,
    output logic [7:0]  out,
    output logic        we,
    output logic [7:0]  ra,
    output logic [7:0]  rb,
    input  logic [31:0] r1,
    input  logic [31:0] r2,
    output logic [31:0] ro,
    output logic        rw,
    output logic [9:0]  sp,
    input  logic [31:0] si,
    output logic [31:0] so,
    output logic        sw
);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [9:0]  sp_q;
    logic [7:0]  opcode_q;
    logic [2:0]  cnt_q;
    logic [7:0]  ops_q [5];
    logic [31:0] maddr_q;
    logic [31:0] wdata_q;

    logic [31:0] alu_y;
    logic [7:0]  op_a, op_b;
    logic [31:0] imm_j;   // JMP/CALL: imm32 starts at first operand byte
    logic [31:0] imm_r;   // LDI/JZ/JNZ: imm32 follows the register byte
    logic [2:0]  last_cnt;
    logic        we_d, rw_d, sw_d;

    assign op_a     = ops_q[0];
    assign op_b     = ops_q[1];
    assign imm_j    = {ops_q[3], ops_q[2], ops_q[1], ops_q[0]};
    assign imm_r    = {ops_q[4], ops_q[3], ops_q[2], ops_q[1]};
    assign last_cnt = instr_len(opcode_q) - 3'd2;

    lis_alu u_alu (
        .op_i (opcode_q),
        .a_i  (r1),
        .b_i  (r2),
        .y_o  (alu_y)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            sp_q     <= '0;
            opcode_q <= '0;
            cnt_q    <= '0;
            maddr_q  <= '0;
            wdata_q  <= '0;
            for (int unsigned i = 0; i < 5; i++) ops_q[i] <= '0;
        end else if (ce) begin
            case (state_q)
                ST_FETCH: begin
                    opcode_q <= in;
                    pc_q     <= pc_q + 32'd1;
                    cnt_q    <= '0;
                    state_q  <= (instr_len(in) == 3'd1) ? ST_EXEC : ST_OPERAND;
                end
                ST_OPERAND: begin
                    ops_q[cnt_q] <= in;
                    pc_q         <= pc_q + 32'd1;
                    cnt_q        <= cnt_q + 3'd1;
                    if (cnt_q == last_cnt) state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    state_q <= ST_FETCH;
                    case (opcode_q)
                        OP_LDB: begin
                            maddr_q <= r2;
                            state_q <= ST_MEM;
                        end
                        OP_STB: begin
                            maddr_q <= r2;
                            wdata_q <= r1;
                            state_q <= ST_MEM;
                        end
                        OP_PUSH: begin
                            sp_q    <= sp_q - 10'd1;
                            wdata_q <= r1;
                            state_q <= ST_STK2;
                        end
                        OP_POP:  sp_q <= sp_q + 10'd1;
                        OP_JMP:  pc_q <= imm_j;
                        OP_JZ:   if (r1 == '0) pc_q <= imm_r;
                        OP_JNZ:  if (r1 != '0) pc_q <= imm_r;
                        OP_CALL: begin
                            // pc_q already points past the CALL: that is the return address
                            sp_q    <= sp_q - 10'd1;
                            wdata_q <= pc_q;
                            pc_q    <= imm_j;
                            state_q <= ST_STK2;
                        end
                        OP_RET: begin
                            pc_q <= si;
                            sp_q <= sp_q + 10'd1;
                        end
                        OP_HLT:  state_q <= ST_HALT;
                        default: state_q <= ST_FETCH;
                    endcase
                end
                ST_MEM:  state_q <= ST_FETCH;
                ST_STK2: state_q <= ST_FETCH;
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        address = pc_q;
        out     = '0;
        ra      = '0;
        rb      = '0;
        ro      = '0;
        so      = '0;
        we_d    = 1'b0;
        rw_d    = 1'b0;
        sw_d    = 1'b0;
        case (state_q)
            ST_EXEC: begin
                ra = op_a;
                rb = op_b;
                case (opcode_q)
                    OP_MOV: begin
                        rw_d = 1'b1;
                        ro   = r2;
                    end
                    OP_LDI: begin
                        rw_d = 1'b1;
                        ro   = imm_r;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                        rw_d = 1'b1;
                        ro   = alu_y;
                    end
                    OP_POP: begin
                        rw_d = 1'b1;
                        ro   = si;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                address = maddr_q;
                ra      = op_a;
                if (opcode_q == OP_LDB) begin
                    rw_d = 1'b1;
                    ro   = {24'h0, in};
                end else begin
                    we_d = 1'b1;
                    out  = wdata_q[7:0];
                end
            end
            ST_STK2: begin
                sw_d = 1'b1;
                so   = wdata_q;
            end
            default: ;
        endcase
    end

    assign sp = sp_q;
    assign we = we_d & ce;
    assign rw = rw_d & ce;
    assign sw = sw_d & ce;

endmodule

// File: tb/tb_lis_cpu.sv
module tb_lis_cpu;

    logic        clock = 1'b0;
    logic        reset, ce;
    logic [31:0] address;
    logic [7:0]  mem_in, mem_out;
    logic        we, rw, sw;
    logic [7:0]  ra, rb;
    logic [31:0] r1, r2, ro, si, so;
    logic [9:0]  sp;

    lis_cpu dut (
        .clock(clock), .reset(reset), .ce(ce), .address(address),
        .in(mem_in), .out(mem_out), .we(we), .ra(ra), .rb(rb),
        .r1(r1), .r2(r2), .ro(ro), .rw(rw), .sp(sp), .si(si),
        .so(so), .sw(sw)
    );

    always #5 clock = ~clock;

    // Fabric: byte memory, register file, stack
    logic [7:0]  mem  [4096];
    logic [31:0] regs [256];
    logic [31:0] stk  [1024];

    assign mem_in = mem[address[11:0]];
    assign r1     = regs[ra];
    assign r2     = regs[rb];
    assign si     = stk[sp];

    always @(posedge clock) begin
        if (we) mem[address[11:0]] <= mem_out;
        if (rw) regs[ra] <= ro;
        if (sw) stk[sp] <= so;
    end

    // Instruction-level reference model producing expected per-cycle bus activity
    typedef struct {
        bit          ca;
        logic [31:0] addr;
        bit          we;
        logic [7:0]  out;
        bit          rw;
        logic [7:0]  ra;
        logic [31:0] ro;
        bit          sw;
        logic [9:0]  sp;
        logic [31:0] so;
    } cyc_t;

    cyc_t        exp_q [$];
    logic [7:0]  mmem  [4096];
    logic [31:0] mregs [256];
    logic [31:0] mstk  [1024];
    logic [31:0] mpc;
    logic [9:0]  msp;
    bit          mhalt;

    int errors = 0;
    int checks = 0;
    int wall = 0;
    int first_rw_wall;
    logic [31:0] first_we_addr;
    logic [7:0]  first_we_out;
    bit          we_logged;
    logic [31:0] rw_log [$];
    bit          run_en = 1'b0;
    bit          we_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", name, wall, act, exp);
        end
    endtask

    function automatic cyc_t blank();
        cyc_t c;
        c.ca = 0; c.addr = '0; c.we = 0; c.out = '0; c.rw = 0;
        c.ra = '0; c.ro = '0; c.sw = 0; c.sp = '0; c.so = '0;
        return c;
    endfunction

    function automatic logic [7:0] mb(input logic [31:0] a);
        return mmem[a[11:0]];
    endfunction

    function automatic int m_len(input logic [7:0] op);
        case (op)
            8'h01, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h20, 8'h21: return 3;
            8'h02, 8'h41, 8'h42: return 6;
            8'h30, 8'h31: return 2;
            8'h40, 8'h50: return 5;
            default: return 1;
        endcase
    endfunction

    task automatic m_step();
        cyc_t c, c2;
        bit has2;
        logic [7:0]  op, a, b;
        logic [31:0] immj, imml, va, vb, res;
        int len;
        if (mhalt) begin
            exp_q.push_back(blank());
            return;
        end
        op  = mb(mpc);
        len = m_len(op);
        for (int i = 0; i < len; i++) begin
            c = blank(); c.ca = 1; c.addr = mpc + i;
            exp_q.push_back(c);
        end
        a    = mb(mpc + 1);
        b    = mb(mpc + 2);
        immj = {mb(mpc + 4), mb(mpc + 3), mb(mpc + 2), mb(mpc + 1)};
        imml = {mb(mpc + 5), mb(mpc + 4), mb(mpc + 3), mb(mpc + 2)};
        va   = mregs[a];
        vb   = mregs[b];
        mpc  = mpc + len;
        c    = blank();
        c2   = blank();
        has2 = 0;
        case (op)
            8'h01: begin c.rw = 1; c.ra = a; c.ro = vb; mregs[a] = vb; end
            8'h02: begin c.rw = 1; c.ra = a; c.ro = imml; mregs[a] = imml; end
            8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16: begin
                case (op)
                    8'h10:   res = va + vb;
                    8'h11:   res = va - vb;
                    8'h12:   res = va & vb;
                    8'h13:   res = va | vb;
                    8'h14:   res = va ^ vb;
                    8'h15:   res = va << vb[4:0];
                    default: res = va >> vb[4:0];
                endcase
                c.rw = 1; c.ra = a; c.ro = res; mregs[a] = res;
            end
            8'h20: begin
                has2 = 1; c2.ca = 1; c2.addr = vb;
                c2.rw = 1; c2.ra = a; c2.ro = {24'h0, mb(vb)};
                mregs[a] = {24'h0, mb(vb)};
            end
            8'h21: begin
                has2 = 1; c2.ca = 1; c2.addr = vb;
                c2.we = 1; c2.out = va[7:0];
                mmem[vb[11:0]] = va[7:0];
            end
            8'h30: begin
                msp = msp - 1;
                has2 = 1; c2.sw = 1; c2.sp = msp; c2.so = va;
                mstk[msp] = va;
            end
            8'h31: begin
                c.rw = 1; c.ra = a; c.ro = mstk[msp]; mregs[a] = mstk[msp];
                msp = msp + 1;
            end
            8'h40: mpc = immj;
            8'h41: if (va == 0) mpc = imml;
            8'h42: if (va != 0) mpc = imml;
            8'h50: begin
                msp = msp - 1;
                has2 = 1; c2.sw = 1; c2.sp = msp; c2.so = mpc;
                mstk[msp] = mpc;
                mpc = immj;
            end
            8'h51: begin mpc = mstk[msp]; msp = msp + 1; end
            8'hFF: mhalt = 1;
            default: ;
        endcase
        exp_q.push_back(c);
        if (has2) exp_q.push_back(c2);
    endtask

    // Compare process: DUT bus activity against the model, every active cycle
    always @(negedge clock) begin
        cyc_t e;
        if (we) we_seen = 1;
        if (run_en && !reset) begin
            if (rw && first_rw_wall < 0) first_rw_wall = wall;
            if (rw) rw_log.push_back(ro);
            if (we && !we_logged) begin
                we_logged = 1; first_we_addr = address; first_we_out = mem_out;
            end
            if (!ce) begin
                chk("strobes_ce0", {29'h0, we, rw, sw}, 32'h0);
            end else if (exp_q.size() == 0) begin
                chk("queue_underflow", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("strobes", {29'h0, we, rw, sw}, {29'h0, e.we, e.rw, e.sw});
                if (e.ca) chk("address", address, e.addr);
                if (e.we) chk("we_out", {24'h0, mem_out}, {24'h0, e.out});
                if (e.rw) begin
                    chk("rw_ra", {24'h0, ra}, {24'h0, e.ra});
                    chk("rw_ro", ro, e.ro);
                end
                if (e.sw) begin
                    chk("sw_sp", {22'h0, sp}, {22'h0, e.sp});
                    chk("sw_so", so, e.so);
                end
            end
            wall++;
        end
    end

    task automatic wr(input int unsigned at, input int n, input logic [47:0] v);
        for (int i = 0; i < n; i++) mem[at + i] = v[8*(n-1-i) +: 8];
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    endtask

    task automatic run(input bit gap);
        for (int i = 0; i < 256; i++) begin regs[i] = '0; mregs[i] = '0; end
        for (int i = 0; i < 1024; i++) begin stk[i] = '0; mstk[i] = '0; end
        for (int i = 0; i < 4096; i++) mmem[i] = mem[i];
        mpc = '0; msp = '0; mhalt = 0;
        exp_q.delete();
        rw_log.delete();
        for (int i = 0; i < 400 && !mhalt; i++) m_step();
        repeat (3) m_step();

        reset = 1; ce = 1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_address", address, 32'h0);
        chk("rst_ra_rb", {16'h0, ra, rb}, 32'h0);
        chk("rst_ro", ro, 32'h0);
        chk("rst_so", so, 32'h0);
        chk("rst_sp_out", {14'h0, sp, mem_out}, 32'h0);
        chk("rst_strobes", {29'h0, we, rw, sw}, 32'h0);
        @(posedge clock);
        #1;
        reset = 0; run_en = 1; wall = 0; first_rw_wall = -1; we_logged = 0;
        if (gap) begin
            repeat (3) @(posedge clock);
            #1 ce = 0;
            repeat (3) @(posedge clock);
            #1 ce = 1;
        end
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clock);
        if (exp_q.size() != 0) chk("run_timeout", exp_q.size(), 0);
        run_en = 0;
    endtask

    task automatic load_a();
        clear_mem();
        wr(0,     6, 48'h020178563412);   // LDI r1,0x12345678
        wr(6,     6, 48'h020105000000);   // LDI r1,5
        wr(12,    6, 48'h020207000000);   // LDI r2,7
        wr(18,    3, 48'h110102);         // SUB r1,r2
        wr(21,    3, 48'h160201);         // SHR r2,r1
        wr(24,    6, 48'h0201AB000000);   // LDI r1,0xAB
        wr(30,    6, 48'h020200010000);   // LDI r2,0x100
        wr(36,    3, 48'h210102);         // STB r1,r2
        wr(39,    3, 48'h200302);         // LDB r3,r2
        wr(42,    2, 48'h3001);           // PUSH r1
        wr(44,    2, 48'h3104);           // POP r4
        wr(46,    5, 48'h4080000000);     // JMP 0x80
        wr('h80,  5, 48'h50A0000000);     // CALL 0xA0
        wr('h85,  6, 48'h020500000000);   // LDI r5,0
        wr('h8B,  6, 48'h410500020000);   // JZ r5,0x200
        wr('hA0,  3, 48'h100304);         // ADD r3,r4
        wr('hA3,  3, 48'h140301);         // XOR r3,r1
        wr('hA6,  1, 48'h51);             // RET
        wr('h200, 6, 48'h420580020000);   // JNZ r5,0x280
        wr('h206, 3, 48'h010603);         // MOV r6,r3
        wr('h209, 3, 48'h150604);         // SHL r6,r4
        wr('h20C, 3, 48'h130601);         // OR r6,r1
        wr('h20F, 1, 48'h07);             // undefined -> NOP
        wr('h210, 1, 48'h00);             // NOP
        wr('h211, 1, 48'hFF);             // HLT
    endtask

    initial begin
        reset = 1; ce = 1;

        load_a();
        run(0);
        chk("lit_first_rw_cycle", first_rw_wall, 6);
        chk("lit_ldi_ro", rw_log[0], 32'h12345678);
        chk("lit_sub_ro", rw_log[3], 32'hFFFFFFFE);
        chk("lit_shr_ro", rw_log[4], 32'h0);
        chk("lit_stb_addr", first_we_addr, 32'h100);
        chk("lit_stb_out", {24'h0, first_we_out}, 32'hAB);
        chk("lit_r3", regs[3], 32'h1FD);
        chk("lit_r4", regs[4], 32'hAB);
        chk("lit_r6", regs[6], 32'hFE8AB);
        chk("lit_mem100", {24'h0, mem[12'h100]}, 32'hAB);
        chk("lit_stk1023", stk[1023], 32'h85);
        chk("lit_model_r6", mregs[6], 32'hFE8AB);
        chk("lit_model_pc", mpc, 32'h212);
        chk("lit_model_sp", {22'h0, msp}, 32'h0);
        chk("lit_sp_after", {22'h0, sp}, 32'h0);

        // Same program with ce held low for 3 cycles during the first LDI
        run(1);
        chk("lit_gap_rw_cycle", first_rw_wall, 9);
        chk("lit_gap_ldi_ro", rw_log[0], 32'h12345678);
        chk("lit_gap_r6", regs[6], 32'hFE8AB);

        // CALL at 0x10 -> 0x20, RET returns to 0x15
        clear_mem();
        wr(0,    5, 48'h4010000000);
        wr('h10, 5, 48'h5020000000);
        wr('h15, 1, 48'hFF);
        wr('h20, 1, 48'h51);
        run(0);
        chk("lit_call_stack", stk[1023], 32'h15);
        chk("lit_call_model_pc", mpc, 32'h16);

        // Reset during the EXEC cycle of STB: write must be dropped
        clear_mem();
        wr(0, 4, 48'h210102FF);
        mem[12'h100] = 8'h55;
        regs[1] = 32'hAB;
        regs[2] = 32'h100;
        reset = 1; ce = 1;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        we_seen = 0;
        repeat (3) @(posedge clock);
        #1 reset = 1;
        repeat (3) @(negedge clock);
        chk("rst_stb_we", {31'h0, we_seen}, 32'h0);
        chk("rst_stb_pc", address, 32'h0);
        chk("rst_stb_mem", {24'h0, mem[12'h100]}, 32'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
